// File: rtl/alu_driver.sv
// Command/response driver for a combinational 4-bit ALU: latches operands, waits SETTLE_CYCLES, captures result.
// Optional statistics counters (op_cnt, ovf_cnt) are enabled by defining ALU_DRIVER_STATS_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for cmd_valid
// DRIVE  | operands held on alu_*, settle counter running down
// RESP   | rsp_valid high, waiting for rsp_ready
module alu_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_mod,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_mod,
  input  logic [3:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_c,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic [2:0] rsp_flags
`ifdef ALU_DRIVER_STATS_EN
  ,
  output logic [7:0] op_cnt,
  output logic [7:0] ovf_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRIVE = 2'b01,
    S_RESP  = 2'b10
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)    state_nxt = S_DRIVE;
      S_DRIVE: if (capture)   state_nxt = S_RESP;
      S_RESP:  if (handshake) state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    capture   = (state == S_DRIVE) && (settle_cnt == 4'd0);
    handshake = (state == S_RESP) && rsp_ready;
  end

  // Handshake flags follow the next state, so cmd_ready rises on the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == S_IDLE);
      rsp_valid <= (state_nxt == S_RESP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_mod    <= 3'b000;
      settle_cnt <= 4'd0;
    end else if (accept) begin
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_mod    <= cmd_mod;
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == S_DRIVE) && (settle_cnt != 4'd0)) begin
      settle_cnt <= settle_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= 4'd0;
      rsp_flags  <= 3'b000;
    end else if (capture) begin
      rsp_result <= alu_result;
      rsp_flags  <= {alu_overflow, alu_c, alu_zero};
    end
  end

`ifdef ALU_DRIVER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt  <= 8'd0;
      ovf_cnt <= 8'd0;
    end else if (handshake) begin
      op_cnt <= op_cnt + 8'd1;
      if (rsp_flags[2]) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: clock edges the ALU inputs are held before the result is captured (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  driver idle, command accepted when cmd_valid also high.
REQ-006 SHALL have port cmd_a  input  4  operand A.
REQ-007 SHALL have port cmd_b  input  4  operand B.
REQ-008 SHALL have port cmd_mod  input  3  ALU operation code, forwarded unmodified (000 add, 001 sub, 010 negate, 011 and, 100 or, 101 xor, 110 compare, 111 default/zero).
REQ-009 SHALL have ports alu_a/alu_b  output  4 each, and alu_mod  output  3, driving the combinational ALU.
REQ-010 SHALL have ports alu_result  input  4, and alu_zero/alu_c/alu_overflow  input  1 each, returned from the ALU.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  consumer takes the response.
REQ-013 SHALL have port rsp_result  output  4  captured alu_result.
REQ-014 SHALL have port rsp_flags  output  3  captured {alu_overflow, alu_c, alu_zero}, bit 2 = overflow.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, RESP; one transaction in flight at most.
REQ-016 SHALL register cmd_ready; high only in IDLE; low in DRIVE and RESP.
REQ-017 SHALL in IDLE, on an edge with cmd_valid && cmd_ready: latch cmd_a/cmd_b/cmd_mod onto alu_a/alu_b/alu_mod, load settle counter with SETTLE_CYCLES-1, enter DRIVE, drop cmd_ready.
REQ-018 SHALL hold alu_a/alu_b/alu_mod stable from acceptance until the next acceptance; cmd_* changes outside acceptance have no effect.
REQ-019 SHALL in DRIVE decrement the counter each edge; on the edge where counter==0: capture alu_result and flags into rsp_result/rsp_flags, set rsp_valid, enter RESP.
REQ-020 SHALL give latency of exactly SETTLE_CYCLES edges from acceptance edge to rsp_valid rising (SETTLE_CYCLES=1: rsp_valid high after the edge following acceptance).
REQ-021 SHALL in RESP hold rsp_valid, rsp_result and rsp_flags constant until an edge with rsp_ready high; on that edge: clear rsp_valid, set cmd_ready, enter IDLE.
REQ-022 SHALL not bypass: a new command is accepted no earlier than the edge after the response handshake (minimum SETTLE_CYCLES+2 edges per transaction with rsp_ready tied high).
REQ-023 SHALL ignore rsp_ready outside RESP and cmd_valid outside IDLE.
REQ-024 SHALL keep rsp_result/rsp_flags at last captured values after handshake until the next capture.

Reset
REQ-025 SHALL, while rst_n low, force state IDLE, cmd_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, alu_a=0, alu_b=0, alu_mod=000, counter=0, irrespective of clk.
REQ-026 SHALL set cmd_ready to 1 on the first rising edge with rst_n high.
REQ-027 SHALL abort any in-flight transaction on reset assertion in DRIVE or RESP; no response is produced for it.

Configuration
REQ-028 SHALL, with macro ALU_DRIVER_STATS_EN defined, add output op_cnt (8 bits, reset 0) incrementing by 1 on each response handshake, wrapping 255->0, plus output ovf_cnt (8 bits, reset 0) incrementing on handshakes where rsp_flags[2]=1, wrapping 255->0.
REQ-029 SHALL, without ALU_DRIVER_STATS_EN, omit op_cnt and ovf_cnt ports and logic entirely; all other behaviour identical.

Verification
REQ-030 SHALL cover: reset release, cmd_valid=1 held -> cmd_ready=0 through reset, 1 after first edge; first accept on that following edge.
REQ-031 SHALL cover: SETTLE_CYCLES=1, A=0111, B=0001, mod=000, ALU model attached, rsp_ready=1 -> rsp_valid one edge after accept, rsp_result=1000, rsp_flags=100.
REQ-032 SHALL cover: SETTLE_CYCLES=4, A=0011, B=0011, mod=001 -> rsp_valid exactly 4 edges after accept, rsp_result=0000, zero flag (bit 0)=1.
REQ-033 SHALL cover: rsp_ready low 10 cycles while cmd_a/cmd_b toggle -> rsp_result/rsp_flags and alu_* stable, cmd_ready=0, no second accept.
REQ-034 SHALL cover: rst_n asserted mid-DRIVE -> all outputs zero immediately, no rsp_valid for aborted op; new command completes normally afterward.
REQ-035 SHALL cover (ALU_DRIVER_STATS_EN): 257 back-to-back add 0111+0001 ops -> op_cnt=1, ovf_cnt=1 after wrap.
